// File: rtl/mem_bus_master.sv
// Single-beat bus initiator for the shared memory bus. Decode, range and alignment are checked
// locally, so a rejected access is answered with rsp_err and never strobes the bus.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   RD    | nRead low, counting RD_WAIT before sampling Dataout
//   WR    | nWrite low and Dataout driven for WR_HOLD cycles
//   TURN  | responder releases Dataout; a new request may be accepted here
//   ERR   | rejected access, error response on the next edge
module mem_bus_master #(
    parameter int         ADDR_W    = 16,
    parameter int         DATA_W    = 256,
    parameter logic [3:0] MEM_EN    = 4'h0,
    parameter int         MEM_WORDS = 14,
    parameter int         RD_WAIT   = 1,
    parameter int         WR_HOLD   = 1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] Address,
    output logic              nRead,
    output logic              nWrite,
    inout  wire  [DATA_W-1:0] Dataout
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_TURN, S_ERR} state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_HOLD - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                nread_q;
    logic                nwrite_q;
    logic                drive_q;
    logic [DATA_W-1:0]   wdata_q;

    logic accept;
    logic addr_bad;

    assign accept   = req_valid && req_ready_q;
    assign addr_bad = (req_addr[15:12] != MEM_EN) ||
                      (int'(req_addr[11:7]) >= MEM_WORDS) ||
                      (req_addr[6:0] != 7'd0);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            nread_q     <= 1'b1;
            nwrite_q    <= 1'b1;
            drive_q     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_TURN: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        if (addr_bad) begin
                            state_q <= S_ERR;
                        end else if (req_write) begin
                            state_q  <= S_WR;
                            addr_q   <= req_addr;
                            nwrite_q <= 1'b0;
                            drive_q  <= 1'b1;
                            wdata_q  <= req_wdata;
                        end else begin
                            state_q <= S_RD;
                            addr_q  <= req_addr;
                            nread_q <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == RD_LAST) begin
                        rsp_rdata_q <= Dataout;
                        rsp_valid_q <= 1'b1;
                        nread_q     <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= S_TURN;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_WR: begin
                    if (cnt_q == WR_LAST) begin
                        nwrite_q    <= 1'b1;
                        drive_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The bus is driven only while a store holds nWrite low.
    assign Dataout   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign Address   = addr_q;
    assign nRead     = nread_q;
    assign nWrite    = nwrite_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: three instances with different wait settings,
// negedge memory responders for the two that return data.
module tb_mem_bus_master;

    localparam logic [255:0] W0 =
        256'h0009_000c_0008_000d_0008_0003_000f_0009_000B_0013_0010_0007_000c_0005_000e_0006;

    logic Clk = 1'b0;
    logic nReset;
    logic req_write;
    logic [15:0] req_addr;
    logic [255:0] req_wdata;
    logic req_valid_a, req_valid_b, req_valid_c;

    logic ready_a, rspv_a, rspe_a, nrd_a, nwr_a;
    logic ready_b, rspv_b, rspe_b, nrd_b, nwr_b;
    logic ready_c, rspv_c, rspe_c, nrd_c, nwr_c;
    logic [255:0] rdata_a, rdata_b, rdata_c;
    logic [15:0] addr_a, addr_b, addr_c;
    tri [255:0] dbus_a, dbus_b, dbus_c;

    logic [255:0] mem [0:31];
    logic resp_en_a = 1'b0, resp_en_b = 1'b0;
    logic [255:0] resp_data_a = '0, resp_data_b = '0;

    int n_tests = 0;
    int n_fail = 0;
    int contention = 0;

    always #5 Clk = ~Clk;

    mem_bus_master #(.RD_WAIT(1), .WR_HOLD(1)) dut_a (
        .Clk(Clk), .nReset(nReset), .req_valid(req_valid_a), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv_a), .rsp_err(rspe_a), .rsp_rdata(rdata_a),
        .Address(addr_a), .nRead(nrd_a), .nWrite(nwr_a), .Dataout(dbus_a));

    mem_bus_master #(.RD_WAIT(3), .WR_HOLD(1)) dut_b (
        .Clk(Clk), .nReset(nReset), .req_valid(req_valid_b), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv_b), .rsp_err(rspe_b), .rsp_rdata(rdata_b),
        .Address(addr_b), .nRead(nrd_b), .nWrite(nwr_b), .Dataout(dbus_b));

    mem_bus_master #(.RD_WAIT(4), .WR_HOLD(3)) dut_c (
        .Clk(Clk), .nReset(nReset), .req_valid(req_valid_c), .req_ready(ready_c),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv_c), .rsp_err(rspe_c), .rsp_rdata(rdata_c),
        .Address(addr_c), .nRead(nrd_c), .nWrite(nwr_c), .Dataout(dbus_c));

    assign dbus_a = resp_en_a ? resp_data_a : {256{1'bz}};
    assign dbus_b = resp_en_b ? resp_data_b : {256{1'bz}};

    // Responders sample the strobes on the falling edge, like the system main memory.
    always @(negedge Clk) begin
        resp_en_a <= !nrd_a;
        if (!nrd_a) resp_data_a <= mem[addr_a[11:7]];
        if (!nwr_a) mem[addr_a[11:7]] <= dbus_a;
        resp_en_b <= !nrd_b;
        if (!nrd_b) resp_data_b <= mem[addr_b[11:7]];
    end

    always @(posedge Clk or negedge Clk) begin
        #2;
        if ((resp_en_a && !nwr_a) || (!nrd_a && !nwr_a) ||
            ((resp_en_a || !nwr_a) && $isunknown(dbus_a)))
            contention++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int lat;
        logic [15:0] bad_addr [3];
        bad_addr[0] = 16'h1000;
        bad_addr[1] = 16'h0700;
        bad_addr[2] = 16'h0505;

        for (int i = 0; i < 32; i++) mem[i] = 256'(i + 100);
        mem[0]  = W0;
        mem[10] = 256'h4;
        mem[11] = 256'he;

        nReset = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0; req_valid_c = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #1 nReset = 1'b0;
        #2;
        chk_b("rst_ready", ready_a, 1'b1);
        chk_b("rst_rspv", rspv_a, 1'b0);
        chk_b("rst_rspe", rspe_a, 1'b0);
        chk_w("rst_rdata", rdata_a, '0);
        chk_n("rst_addr", int'(addr_a), 0);
        chk_b("rst_nread", nrd_a, 1'b1);
        chk_b("rst_nwrite", nwr_a, 1'b1);
        tick();
        tick();
        nReset = 1'b1;

        // Load word 0
        req_valid_a = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
        tick();
        req_valid_a = 1'b0;
        chk_b("ld0_ready_low", ready_a, 1'b0);
        chk_b("ld0_nread", nrd_a, 1'b0);
        chk_b("ld0_nwrite", nwr_a, 1'b1);
        tick();
        chk_b("ld0_rspv", rspv_a, 1'b1);
        chk_b("ld0_rspe", rspe_a, 1'b0);
        chk_w("ld0_rdata", rdata_a, W0);
        chk_b("ld0_nread_rel", nrd_a, 1'b1);
        tick();
        chk_b("ld0_pulse_end", rspv_a, 1'b0);
        chk_b("ld0_ready_back", ready_a, 1'b1);

        // Store word 2, then load it back with req_valid held throughout
        req_valid_a = 1'b1; req_write = 1'b1; req_addr = 16'h0100; req_wdata = 256'hABCD;
        tick();
        chk_b("st_nwrite", nwr_a, 1'b0);
        chk_n("st_addr", int'(addr_a), 'h100);
        chk_w("st_bus", dbus_a, 256'hABCD);
        chk_b("st_ready_low", ready_a, 1'b0);
        req_write = 1'b0; req_wdata = 256'h0;
        tick();
        chk_b("st_ack", rspv_a, 1'b1);
        chk_b("st_ack_err", rspe_a, 1'b0);
        chk_w("st_rdata_keep", rdata_a, W0);
        chk_b("st_nwrite_rel", nwr_a, 1'b1);
        tick();
        chk_b("ld2_nread", nrd_a, 1'b0);
        tick();
        chk_b("ld2_rspv", rspv_a, 1'b1);
        chk_w("ld2_rdata", rdata_a, 256'hABCD);
        // Store right after the load: accepted on the turnaround edge
        req_write = 1'b1; req_addr = 16'h0180; req_wdata = 256'h1234;
        tick();
        req_valid_a = 1'b0;
        chk_b("st3_nwrite", nwr_a, 1'b0);
        chk_w("st3_bus", dbus_a, 256'h1234);
        tick();
        chk_b("st3_ack", rspv_a, 1'b1);
        req_write = 1'b0;

        // Rejected accesses
        for (int i = 0; i < 3; i++) begin
            req_valid_a = 1'b1; req_addr = bad_addr[i];
            tick();
            req_valid_a = 1'b0;
            chk_b($sformatf("err%0d_nread_t", i), nrd_a, 1'b1);
            chk_b($sformatf("err%0d_nwrite_t", i), nwr_a, 1'b1);
            chk_b($sformatf("err%0d_rspv_t", i), rspv_a, 1'b0);
            tick();
            chk_b($sformatf("err%0d_rspv", i), rspv_a, 1'b1);
            chk_b($sformatf("err%0d_rspe", i), rspe_a, 1'b1);
            chk_w($sformatf("err%0d_rdata", i), rdata_a, '0);
            chk_b($sformatf("err%0d_nread", i), nrd_a, 1'b1);
            chk_n($sformatf("err%0d_addr", i), int'(addr_a), 'h180);
        end
        tick();
        chk_b("err_rspe_clear", rspe_a, 1'b0);

        // Back-to-back loads of words 10 and 11
        req_valid_a = 1'b1; req_addr = 16'h0500;
        tick();
        req_addr = 16'h0580;
        tick();
        chk_w("b2b_rdata10", rdata_a, 256'h4);
        chk_b("b2b_ready_turn", ready_a, 1'b1);
        tick();
        req_valid_a = 1'b0;
        chk_b("b2b_second_accept", nrd_a, 1'b0);
        chk_n("b2b_addr", int'(addr_a), 'h580);
        tick();
        chk_b("b2b_rspv11", rspv_a, 1'b1);
        chk_w("b2b_rdata11", rdata_a, 256'he);
        tick();
        chk_n("no_contention", contention, 0);

        // Reset while instance B is mid-read
        req_valid_b = 1'b1; req_addr = 16'h0500;
        tick();
        req_valid_b = 1'b0;
        chk_b("rb_nread", nrd_b, 1'b0);
        tick();
        #2 nReset = 1'b0;
        #1;
        chk_b("rb_nread_rst", nrd_b, 1'b1);
        chk_b("rb_ready_rst", ready_b, 1'b1);
        chk_n("rb_addr_rst", int'(addr_b), 0);
        chk_b("rb_rspv_rst", rspv_b, 1'b0);
        tick();
        nReset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rspv_b) cnt++;
            tick();
        end
        chk_n("rb_no_rsp", cnt, 0);
        req_valid_b = 1'b1; req_addr = 16'h0500;
        tick();
        req_valid_b = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rspv_b && lat < 0) begin
                lat = i;
                chk_w("rb_rdata", rdata_b, 256'h4);
            end
        end
        chk_n("rb_latency", lat, 3);

        // Strobe widths with RD_WAIT=4, WR_HOLD=3
        req_valid_c = 1'b1; req_write = 1'b0; req_addr = 16'h0500;
        tick();
        req_valid_c = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!nrd_c) cnt++;
            tick();
        end
        chk_n("c_nread_width", cnt, 4);
        req_valid_c = 1'b1; req_write = 1'b1; req_addr = 16'h0180; req_wdata = 256'h5;
        tick();
        req_valid_c = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!nwr_c) cnt++;
            tick();
        end
        chk_n("c_nwrite_width", cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
